teclado_4x4_lector: RTL and testbench
=====================================

Name: teclado_4x4_lector

Overview:
- Scans a 4x4 matrix keypad and delivers debounced key codes to the display/state logic in the 50 MHz domain.
- It is the input-side reader for the front panel that the seven-segment display writer presents.
- It drives one keypad row low at a time, samples the four column lines, and debounces both press and release.
- For each debounced press it emits one 4-bit code with a single-cycle valid pulse.

Parameters:
- SCAN_DIV, 50_000: clock_50mhz cycles per scan tick (1 ms at 50 MHz); must be >= 4.
- DEBOUNCE_CNT, 16: consecutive matching scan ticks required to accept a press or a release; must be >= 2.

Ports:
- clock_50mhz  input  1  system clock, 50 MHz crystal.
- reset_n  input  1  asynchronous reset, active low.
- filas  output  4  keypad row drive, active low, exactly one bit low at any time.
- columnas  input  4  keypad column sense, active low, externally pulled up, asynchronous to clock.
- tecla  output  4  code of the last accepted key, equal to row*4 + column.
- tecla_valida  output  1  one-cycle pulse when a new debounced press is accepted.
- tecla_presionada  output  1  level, high from press acceptance until release acceptance.

Behaviour:
- Reset (asynchronous, reset_n=0) sets:
  - filas=4'b1110 (row 0) and state=SCAN.
  - tecla=0, tecla_valida=0, tecla_presionada=0.
  - Prescaler, debounce counter, release counter and synchronizer flops to 0 / all-ones (synchronizer idle = 4'b1111).
- Reset mid-operation returns to these values immediately. No key is reported for a press that was in progress.
- Synchronizer: columnas passes through a 2-flop synchronizer. All decisions use the synchronized value col_s.
- Prescaler: counts 0..SCAN_DIV-1 and wraps.
  - tick=1 for one cycle when the count equals SCAN_DIV-1.
  - Counter width is clog2(SCAN_DIV).
  - All state actions below happen only on tick cycles.
- Column select: if several col_s bits are low, the lowest-index low column wins. The candidate code is row*4 + that column.
- SCAN state:
  - On tick with col_s==4'b1111: rotate filas to the next row (0->1->2->3->0).
  - On tick with any col_s bit low: latch the candidate code, freeze filas, set debounce count=1, go to DEBOUNCE.
- DEBOUNCE state:
  - On tick, if the candidate code recomputed from col_s matches the latched code: increment the count.
  - On mismatch or no column low: clear the count, return to SCAN, and advance to the next row on that same tick.
  - When the count reaches DEBOUNCE_CNT:
    - tecla <= latched code.
    - tecla_valida=1 for exactly the next clock cycle.
    - tecla_presionada=1.
    - Go to HELD with release count=0.
  - Latency: tecla_valida asserts 1 cycle after the DEBOUNCE_CNT-th consecutive matching tick. The detection tick counts as the 1st.
- HELD state:
  - filas stays frozen.
  - On tick with col_s==4'b1111: increment the release count. Any column low clears it.
  - When the release count reaches DEBOUNCE_CNT: tecla_presionada=0, advance filas to the next row, go to SCAN.
  - tecla keeps its value after release.
- Second key while HELD: presses in another column of the same row hold off release. Presses in other rows are not visible. No second tecla_valida is produced in either case. Auto-repeat is not supported.
- Bounce: any non-matching tick during DEBOUNCE aborts the press. Any low tick during release debounce restarts the release count.
- Settling: filas changes only on tick, so each row is stable for SCAN_DIV cycles before it is sampled. This exceeds the 2-cycle synchronizer latency.
- tecla_valida is never high for 2 consecutive cycles. It is never high outside the DEBOUNCE->HELD transition.

Test Plan:
- Sim parameters: SCAN_DIV=4, DEBOUNCE_CNT=3.
- Reset, no keys: filas cycles 1110->1101->1011->0111->1110, one step per 4 clocks. tecla=0, tecla_valida and tecla_presionada stay 0.
- Clean press of row 2, column 1, modelled as columnas[1]=0 while filas[2]=0 and held: exactly one tecla_valida pulse; tecla=9, tecla_presionada=1, filas frozen at 1011. After release, tecla_presionada=0 3 ticks later and scanning resumes at row 3.
- Bouncy press of row 0, column 3: columnas[3] toggles low/high on alternate ticks for 4 ticks, then stays low. No pulse during the toggling. A single pulse follows with tecla=3, 3 ticks after the stable low begins.
- Simultaneous row 1, columns 0 and 2 low: tecla=4 (lowest column wins), one pulse only.
- Hold row 3, column 3 (tecla=15), then press row 0, column 0: no new pulse. Release both: tecla_presionada falls, and tecla remains 15.
- Assert reset_n=0 during DEBOUNCE (after 2 matching ticks): outputs go to reset values immediately. No pulse after reset_n rises unless the press is re-debounced for the full 3 ticks.

Source files
------------

// File: rtl/teclado_4x4_lector.sv
// 4x4 matrix keypad reader: row scan, column synchronizer, press/release
// debounce, and a one-cycle valid pulse per accepted key.
module teclado_4x4_lector #(
  parameter int unsigned SCAN_DIV     = 50_000,
  parameter int unsigned DEBOUNCE_CNT = 16
) (
  input  logic       clock_50mhz,
  input  logic       reset_n,
  output logic [3:0] filas,
  input  logic [3:0] columnas,
  output logic [3:0] tecla,
  output logic       tecla_valida,
  output logic       tecla_presionada
);

  localparam int unsigned PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  logic [3:0]         col_meta_q;
  logic [3:0]         col_s_q;
  logic [PRESC_W-1:0] presc_q;
  logic               tick;

  state_e             state_q, state_d;
  logic [3:0]         filas_q, filas_d;
  logic [3:0]         cand_q, cand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   rel_q, rel_d;
  logic [3:0]         tecla_q, tecla_d;
  logic               valida_q, valida_d;
  logic               pres_q, pres_d;

  logic               col_hit;
  logic [1:0]         col_idx;
  logic [1:0]         row_idx;
  logic [3:0]         cand_now;
  logic [3:0]         filas_next;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   rel_inc;

  // Two-flop synchronizer for the asynchronous column lines
  always_ff @(posedge clock_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      col_meta_q <= 4'hF;
      col_s_q    <= 4'hF;
    end else begin
      col_meta_q <= columnas;
      col_s_q    <= col_meta_q;
    end
  end

  assign tick = (presc_q == PRESC_W'(SCAN_DIV - 1));

  // Scan prescaler: wraps every SCAN_DIV cycles, tick on the last count
  always_ff @(posedge clock_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRESC_W'(1);
    end
  end

  // Lowest-index low column wins when several are pressed
  always_comb begin
    col_hit = 1'b0;
    col_idx = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (!col_s_q[c]) begin
        col_hit = 1'b1;
        col_idx = 2'(c);
      end
    end
  end

  // Row index of the currently driven (low) row
  always_comb begin
    row_idx = 2'd0;
    unique case (filas_q)
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  assign cand_now   = {row_idx, col_idx};
  assign filas_next = {filas_q[2:0], filas_q[3]};
  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign rel_inc    = rel_q + CNT_W'(1);

  // Scan / debounce / held state register and datapath registers
  always_ff @(posedge clock_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_SCAN;
      filas_q  <= 4'b1110;
      cand_q   <= 4'd0;
      cnt_q    <= '0;
      rel_q    <= '0;
      tecla_q  <= 4'd0;
      valida_q <= 1'b0;
      pres_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      filas_q  <= filas_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      rel_q    <= rel_d;
      tecla_q  <= tecla_d;
      valida_q <= valida_d;
      pres_q   <= pres_d;
    end
  end

  // Next-state logic; every action is qualified by the scan tick
  always_comb begin
    state_d  = state_q;
    filas_d  = filas_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    rel_d    = rel_q;
    tecla_d  = tecla_q;
    valida_d = 1'b0;
    pres_d   = pres_q;

    if (tick) begin
      unique case (state_q)
        ST_SCAN: begin
          if (col_hit) begin
            cand_d  = cand_now;
            cnt_d   = CNT_W'(1);
            state_d = ST_DEBOUNCE;
          end else begin
            filas_d = filas_next;
          end
        end

        ST_DEBOUNCE: begin
          if (col_hit && (cand_now == cand_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE_CNT)) begin
              tecla_d  = cand_q;
              valida_d = 1'b1;
              pres_d   = 1'b1;
              rel_d    = '0;
              state_d  = ST_HELD;
            end
          end else begin
            cnt_d   = '0;
            filas_d = filas_next;
            state_d = ST_SCAN;
          end
        end

        ST_HELD: begin
          if (!col_hit) begin
            rel_d = rel_inc;
            if (rel_inc == CNT_W'(DEBOUNCE_CNT)) begin
              pres_d  = 1'b0;
              rel_d   = '0;
              cnt_d   = '0;
              filas_d = filas_next;
              state_d = ST_SCAN;
            end
          end else begin
            rel_d = '0;
          end
        end

        default: begin
          state_d = ST_SCAN;
          filas_d = 4'b1110;
        end
      endcase
    end
  end

  assign filas            = filas_q;
  assign tecla            = tecla_q;
  assign tecla_valida     = valida_q;
  assign tecla_presionada = pres_q;

endmodule

// File: tb/tb_teclado_4x4_lector.sv
// Bench for teclado_4x4_lector: physical keypad model, tick-level reference
// model checked every cycle, table-driven presses and hand-written corner cases.
module tb_teclado_4x4_lector;

  localparam int unsigned SD = 4;
  localparam int unsigned DB = 3;

  localparam int M_SCAN = 0;
  localparam int M_DEB  = 1;
  localparam int M_HELD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  filas;
  logic [3:0]  columnas;
  logic [3:0]  tecla;
  logic        valida;
  logic        pres;
  logic [15:0] keys;

  int tests  = 0;
  int fails  = 0;
  int pulses = 0;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  exp_tecla;
    logic [3:0]  exp_frozen;
    logic [3:0]  exp_next;
  } vec_t;

  vec_t vecs[7];

  teclado_4x4_lector #(
    .SCAN_DIV     (SD),
    .DEBOUNCE_CNT (DB)
  ) dut (
    .clock_50mhz      (clk),
    .reset_n          (rst_n),
    .filas            (filas),
    .columnas         (columnas),
    .tecla            (tecla),
    .tecla_valida     (valida),
    .tecla_presionada (pres)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key shorts its column to its row; columns pulled up
  always_comb begin
    columnas = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keys[r*4+c] && !filas[r]) columnas[c] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] row_drive(input int r);
    logic [3:0] f;
    f = 4'hF;
    f[r] = 1'b0;
    return f;
  endfunction

  // Reference model: per-tick rules on the 2-cycle-delayed column value
  int         m_cyc, m_row, m_mode, m_run, m_rel, m_cand;
  logic [3:0] m_s1, m_s2, m_tecla;
  logic       m_valid, m_pres;

  task automatic model_tick(input logic [3:0] cs);
    int col;
    int key;
    col = -1;
    for (int c = 0; c < 4; c++) if (!cs[c] && col < 0) col = c;
    key = (col < 0) ? -1 : m_row * 4 + col;
    case (m_mode)
      M_SCAN: begin
        if (col >= 0) begin
          m_cand = key; m_run = 1; m_mode = M_DEB;
        end else m_row = (m_row + 1) % 4;
      end
      M_DEB: begin
        if (key == m_cand) begin
          m_run++;
          if (m_run == DB) begin
            m_tecla = 4'(m_cand); m_valid = 1'b1; m_pres = 1'b1;
            m_mode = M_HELD; m_rel = 0;
          end
        end else begin
          m_run = 0; m_mode = M_SCAN; m_row = (m_row + 1) % 4;
        end
      end
      default: begin
        if (cs == 4'hF) begin
          m_rel++;
          if (m_rel == DB) begin
            m_pres = 1'b0; m_row = (m_row + 1) % 4; m_mode = M_SCAN;
          end
        end else m_rel = 0;
      end
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0; m_row = 0; m_mode = M_SCAN; m_run = 0; m_rel = 0; m_cand = 0;
      m_s1 = 4'hF; m_s2 = 4'hF; m_tecla = 4'd0; m_valid = 1'b0; m_pres = 1'b0;
    end else begin
      m_valid = 1'b0;
      if ((m_cyc % SD) == SD - 1) model_tick(m_s2);
      m_cyc++;
      m_s2 = m_s1;
      m_s1 = columnas;
    end
  end

  // Every-cycle comparison against the model, plus pulse counting
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("cycle_model", {filas, tecla, valida, pres},
            {row_drive(m_row), m_tecla, m_valid, m_pres});
      if (valida) pulses++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pres(input logic level, input int budget, input string name);
    int n;
    n = 0;
    while (pres !== level && n < budget) begin
      step();
      n++;
    end
    if (pres !== level) check(name, 32'(pres), 32'(level));
  endtask

  task automatic wait_filas(input logic [3:0] f, input int budget, input string name);
    int n;
    n = 0;
    while (filas !== f && n < budget) begin
      step();
      n++;
    end
    if (filas !== f) check(name, 32'(filas), 32'(f));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    vecs[0] = '{16'h0200, 4'd9,  4'b1011, 4'b0111};
    vecs[1] = '{16'h0050, 4'd4,  4'b1101, 4'b1011};
    vecs[2] = '{16'h0008, 4'd3,  4'b1110, 4'b1101};
    vecs[3] = '{16'h8000, 4'd15, 4'b0111, 4'b1110};
    vecs[4] = '{16'h1000, 4'd12, 4'b0111, 4'b1110};
    vecs[5] = '{16'h0001, 4'd0,  4'b1110, 4'b1101};
    vecs[6] = '{16'h0C00, 4'd10, 4'b1011, 4'b0111};

    rst_n = 1'b0;
    keys  = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_filas", 32'(filas), 32'(4'b1110));
    check("reset_tecla", 32'(tecla), 32'd0);
    check("reset_valida", 32'(valida), 32'd0);
    check("reset_pres", 32'(pres), 32'd0);

    // Idle scan: one row step every SD clocks, starting from row 0
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      check("scan_row", 32'(filas), 32'(row_drive((k / 4) % 4)));
    end
    check("idle_tecla", 32'(tecla), 32'd0);
    check("idle_pulses", 32'(pulses), 32'd0);

    // Table of clean presses and releases
    foreach (vecs[i]) begin
      p0 = pulses;
      keys = vecs[i].keys;
      wait_pres(1'b1, 80, "press_timeout");
      repeat (8) step();
      check("press_pulses", 32'(pulses - p0), 32'd1);
      check("press_tecla", 32'(tecla), 32'(vecs[i].exp_tecla));
      check("press_level", 32'(pres), 32'd1);
      check("press_frozen", 32'(filas), 32'(vecs[i].exp_frozen));
      keys = 16'h0;
      wait_pres(1'b0, 60, "release_timeout");
      check("release_next_row", 32'(filas), 32'(vecs[i].exp_next));
      check("release_tecla", 32'(tecla), 32'(vecs[i].exp_tecla));
      check("release_pulses", 32'(pulses - p0), 32'd1);
      repeat (4) step();
    end

    // Hold 15, press a key in another row: invisible, no second pulse
    p0 = pulses;
    keys = 16'h8000;
    wait_pres(1'b1, 80, "hold15_timeout");
    keys = 16'h8001;
    repeat (30) step();
    check("other_row_pulses", 32'(pulses - p0), 32'd1);
    check("other_row_tecla", 32'(tecla), 32'd15);
    check("other_row_frozen", 32'(filas), 32'(4'b0111));
    keys = 16'h0;
    wait_pres(1'b0, 60, "hold15_release_timeout");
    check("other_row_keep_tecla", 32'(tecla), 32'd15);

    // Same-row second key holds off the release
    p0 = pulses;
    keys = 16'h0200;
    wait_pres(1'b1, 80, "same_row_timeout");
    keys = 16'h0600;
    repeat (6) step();
    keys = 16'h0400;
    repeat (30) step();
    check("same_row_still_held", 32'(pres), 32'd1);
    check("same_row_pulses", 32'(pulses - p0), 32'd1);
    check("same_row_tecla", 32'(tecla), 32'd9);
    keys = 16'h0;
    wait_pres(1'b0, 60, "same_row_release_timeout");

    // Bouncy press on row 0, column 3
    wait_filas(4'b1110, 40, "bounce_sync_timeout");
    p0 = pulses;
    for (int t = 0; t < 4; t++) begin
      keys = (t % 2 == 0) ? 16'h0008 : 16'h0000;
      repeat (SD) step();
    end
    check("bounce_no_pulse", 32'(pulses - p0), 32'd0);
    keys = 16'h0008;
    wait_pres(1'b1, 80, "bounce_press_timeout");
    repeat (4) step();
    check("bounce_pulses", 32'(pulses - p0), 32'd1);
    check("bounce_tecla", 32'(tecla), 32'd3);
    keys = 16'h0;
    wait_pres(1'b0, 60, "bounce_release_timeout");

    // Reset after two matching debounce ticks on row 1, column 1
    wait_filas(4'b1101, 40, "rst_sync_timeout");
    keys = 16'h0020;
    repeat (2 * SD) step();
    rst_n = 1'b0;
    #1;
    check("midrst_filas", 32'(filas), 32'(4'b1110));
    check("midrst_tecla", 32'(tecla), 32'd0);
    check("midrst_valida", 32'(valida), 32'd0);
    check("midrst_pres", 32'(pres), 32'd0);
    p0 = pulses;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (8) step();
    check("midrst_no_early_pulse", 32'(pulses - p0), 32'd0);
    wait_pres(1'b1, 80, "midrst_repress_timeout");
    check("midrst_tecla_after", 32'(tecla), 32'd5);
    check("midrst_pulses_after", 32'(pulses - p0), 32'd1);
    keys = 16'h0;
    wait_pres(1'b0, 60, "midrst_release_timeout");

    // Random key activity, checked cycle by cycle against the model
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 4))
        0: keys = 16'h0;
        1: keys = 16'(1) << $urandom_range(0, 15);
        2: keys = 16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3));
        3: begin
          keys = 16'(1) << $urandom_range(0, 15);
          for (int b = 0; b < 4; b++) begin
            repeat ($urandom_range(1, 6)) step();
            keys = (b % 2 == 0) ? 16'h0 : (16'(1) << $urandom_range(0, 15));
          end
        end
        default: keys = 16'($urandom);
      endcase
      repeat ($urandom_range(3, 50)) step();
      if ($urandom_range(0, 2) == 0) begin
        keys = 16'h0;
        repeat ($urandom_range(5, 30)) step();
      end
    end
    keys = 16'h0;
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
